// File: rtl/dir_select_ctrl.sv
// dir_select_ctrl: synchronises and debounces the UP/DOWN push-buttons and
// drives single-cycle set/reset pulses into the counter's direction latch.
module dir_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    output logic set_o,
    output logic reset_o,
    output logic dir,
    output logic conflict
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the UP button, bit 1 the DOWN button, in every vector below.
    logic [1:0]       btn_raw;
    logic [1:0]       sync_meta;
    logic [1:0]       sync_q;
    logic [1:0]       stb;
    logic [1:0]       accept;
    logic [1:0]       press;
    logic [CNT_W-1:0] cnt [2];

    assign btn_raw = {btn_down, btn_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    // An accept fires on the edge where the level has differed for a full count.
    always_comb begin
        accept = '0;
        press  = '0;
        for (int i = 0; i < 2; i++) begin
            accept[i] = (sync_q[i] != stb[i]) && (cnt[i] == CNT_LAST);
            press[i]  = accept[i] && sync_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                stb[i] <= 1'b0;
                cnt[i] <= '0;
            end else if (sync_q[i] == stb[i]) begin
                cnt[i] <= '0;
            end else if (accept[i]) begin
                stb[i] <= sync_q[i];
                cnt[i] <= '0;
            end else begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Simultaneous presses are flagged and suppressed so S and R never overlap.
    always_ff @(posedge clk) begin
        if (rst) begin
            set_o    <= 1'b0;
            reset_o  <= 1'b0;
            conflict <= 1'b0;
            dir      <= 1'b1;
        end else begin
            set_o    <= press[0] && !press[1];
            reset_o  <= press[1] && !press[0];
            conflict <= press[0] && press[1];
            if (press[0] && !press[1]) begin
                dir <= 1'b1;
            end else if (press[1] && !press[0]) begin
                dir <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dir_select_ctrl.md
# dir_select_ctrl

Push-button front end for the lab counter's UP/DOWN direction selection. It synchronises and debounces two raw buttons and turns each debounced press into a single-cycle set or reset pulse on the direction latch interface. It also keeps a registered copy of the selected direction. The block sits between the board buttons and the counter's direction-latch input; it is the driving end of the S/R interface.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised button level must hold before it is accepted. Legal range is ≥2; 1000000 is 10 ms at 100 MHz.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- btn_up  in  1  raw UP button, asynchronous, active-high.
- btn_down  in  1  raw DOWN button, asynchronous, active-high.
- set_o  out  1  one-cycle pulse that selects UP (drives latch S).
- reset_o  out  1  one-cycle pulse that selects DOWN (drives latch R).
- dir  out  1  registered direction: 1 = UP, 0 = DOWN.
- conflict  out  1  one-cycle pulse when both buttons are accepted as pressed on the same edge.

## Operation
- **Synchroniser:** each button passes through its own 2-flop synchroniser. Only the second-stage value (sync) is used further.
- **Debouncer (per button):** holds a stable level `stb` and a counter `cnt`.
  - If sync == stb, then cnt ← 0.
  - If sync != stb and cnt < DEBOUNCE_CYCLES-1, then cnt ← cnt+1.
  - If sync != stb and cnt == DEBOUNCE_CYCLES-1, then stb ← sync and cnt ← 0. This is an accept event.
  - Any return of sync to stb before acceptance clears cnt, so a bounce restarts the count.
- **Press event:** an accept event where stb goes 0→1. Releases (1→0) are debounced the same way but produce no output.
- **Output decode, evaluated on each edge from the press events of that edge:**
  - UP press only: set_o = 1 and dir ← 1 on the same edge.
  - DOWN press only: reset_o = 1 and dir ← 0.
  - Both press on the same edge: conflict = 1, set_o = reset_o = 0, dir unchanged.
  - Otherwise: all pulses are 0.
- **Invariant:** set_o and reset_o are never high in the same cycle, so the forbidden S=R=1 state is never driven.
- **Repeated press:** pressing UP while dir is already 1 still pulses set_o; dir stays 1. DOWN behaves the same way.
- **Overlapping presses:** a press while the other button is held is legal, and the latest accepted press wins. Example: UP held, DOWN accepted gives reset_o and dir = 0.
- **No auto-repeat:** holding a button produces exactly one pulse. A new pulse requires an accepted release followed by an accepted press.

## Timing
- **Reset values (after an edge with rst = 1):**
  - synchroniser flops = 0, stb = 0, cnt = 0
  - set_o = reset_o = conflict = 0
  - dir = 1
- rst has priority over every other event. Asserting rst mid-count discards the partial count, and a button still held after reset must be re-accepted with a full DEBOUNCE_CYCLES count.
- **Latency:** let button X first be sampled high at edge 0 and held.
  - sync = 1 after edge 1.
  - cnt increments at edges 2..DEBOUNCE_CYCLES.
  - Accept happens at edge DEBOUNCE_CYCLES+1.
  - The pulse and dir are high/updated in the cycle after edge DEBOUNCE_CYCLES+1.
  - The pulse is exactly 1 cycle wide.
- **Release latency:** identical (DEBOUNCE_CYCLES+1 edges), with no pulse.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** DEBOUNCE_CYCLES=4; assert rst for 2 cycles with both buttons low. Required: dir=1, set_o=reset_o=conflict=0 through 20 idle cycles.
- **Clean DOWN press:** DEBOUNCE_CYCLES=4; btn_down high from edge 0 and held 20 cycles. Required: reset_o=1 only in the cycle after edge 5; dir=0 from that cycle on; no further pulses while held.
- **Bounce rejection:** btn_up toggles 1,1,1,0 repeatedly for 40 cycles, then holds 1. Required: no set_o during the bounce; one set_o exactly 5 edges after the final steady 1 is first sampled; dir=1.
- **Simultaneous press:** btn_up and btn_down rise on the same edge and are held. Required: conflict=1 for one cycle after edge 5; set_o=reset_o=0 throughout; dir unchanged.
- **Overlap and release:** hold UP, which gives set_o and dir=1. Then press DOWN 10 cycles later, giving reset_o and dir=0. Release both, then re-press UP. Required: exactly three pulses in that order; never set_o & reset_o together.
- **Reset mid-count:** btn_up held; assert rst at edge 3 for one cycle. Required: no set_o at edge 5; set_o appears 5 edges after reset deasserts (first post-reset sample counts as edge 0).
